// File: rtl/membus_arbiter_if.sv
// membus request/response bundle: valid/ready request channel, rvalid/rdata response channel.
interface membus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/membus_arbiter.sv
// Shares one membus memory between instruction and data ports, one transaction in flight, zero added latency.
// MEMBUS_ARBITER_RR_EN: round-robin tie-break on simultaneous requests; otherwise fixed priority via D_PRIORITY.
module membus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit D_PRIORITY = 1'b1
) (
  input logic      clk,
  input logic      rst,
  membus_if.slave  i_membus,
  membus_if.slave  d_membus,
  membus_if.master mem_membus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic       PORT_I  = 1'b0;
  localparam logic       PORT_D  = 1'b1;

  logic [0:0] r_state;
  logic       r_owner;
  logic       r_lock_vld;
  logic       r_lock_port;
  logic       r_rr_last;

  logic                    w_resp;
  logic                    w_issue;
  logic                    w_grant;
  logic                    w_grant_vld;
  logic                    w_sel_d;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_wen;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH/8-1:0] w_wmask;

  // The response cycle doubles as an issue slot so reads can stream at one per cycle.
  assign w_resp  = (r_state == ST_BUSY) && mem_membus.rvalid;
  assign w_issue = (r_state == ST_IDLE) || w_resp;

  always_comb begin
    w_grant = PORT_I;
    if (r_lock_vld) begin
      w_grant = r_lock_port;
    end else if (i_membus.valid && d_membus.valid) begin
`ifdef MEMBUS_ARBITER_RR_EN
      w_grant = ~r_rr_last;
`else
      w_grant = D_PRIORITY ? PORT_D : PORT_I;
`endif
    end else if (d_membus.valid) begin
      w_grant = PORT_D;
    end
  end

  assign w_grant_vld = w_issue && ((w_grant == PORT_D) ? d_membus.valid : i_membus.valid);
  assign w_sel_d     = w_grant_vld && (w_grant == PORT_D);
  assign w_accept    = w_grant_vld && mem_membus.ready;

  assign w_addr  = w_sel_d ? d_membus.addr  : i_membus.addr;
  assign w_wen   = w_sel_d ? d_membus.wen   : i_membus.wen;
  assign w_wdata = w_sel_d ? d_membus.wdata : i_membus.wdata;
  assign w_wmask = w_sel_d ? d_membus.wmask : i_membus.wmask;

  assign mem_membus.valid = w_grant_vld;
  assign mem_membus.addr  = w_addr;
  assign mem_membus.wen   = w_wen;
  assign mem_membus.wdata = w_wdata;
  assign mem_membus.wmask = w_wmask;

  assign i_membus.ready  = w_grant_vld && !w_sel_d && mem_membus.ready;
  assign d_membus.ready  = w_sel_d && mem_membus.ready;
  assign i_membus.rvalid = w_resp && (r_owner == PORT_I);
  assign d_membus.rvalid = w_resp && (r_owner == PORT_D);
  assign i_membus.rdata  = mem_membus.rdata;
  assign d_membus.rdata  = mem_membus.rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= PORT_I;
      r_lock_vld  <= 1'b0;
      r_lock_port <= PORT_I;
      r_rr_last   <= PORT_D;
    end else begin
      if (w_accept) begin
        r_state    <= ST_BUSY;
        r_owner    <= w_grant;
        r_lock_vld <= 1'b0;
      end else begin
        if (w_resp) begin
          r_state <= ST_IDLE;
        end
        // A stalled request pins the grant until the memory takes it.
        if (w_grant_vld) begin
          r_lock_vld  <= 1'b1;
          r_lock_port <= w_grant;
        end
      end
      r_rr_last <= w_accept ? w_grant : r_rr_last;
    end
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_membus_arbiter;
  localparam bit D_PRIO = 1'b1;
`ifdef MEMBUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  membus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i_bus ();
  membus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) d_bus ();
  membus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_bus ();

  membus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .D_PRIORITY(D_PRIO)) dut (
    .clk(clk),
    .rst(rst),
    .i_membus(i_bus),
    .d_membus(d_bus),
    .mem_membus(m_bus)
  );

  always #5 clk = ~clk;

  // Memory slave: reads answer one cycle after accept, writes two cycles after accept.
  logic        mdl_clr;
  logic        mem_rdy;
  logic        bd_en;
  logic [7:0]  bd_idx;
  logic [31:0] bd_dat;
  logic [31:0] mem [0:255];
  logic [1:0]  pend;
  logic [31:0] rd_q;

  assign m_bus.ready  = mem_rdy;
  assign m_bus.rvalid = (pend == 2'd1);
  assign m_bus.rdata  = rd_q;

  always @(posedge clk) begin
    if (bd_en) mem[bd_idx] <= bd_dat;
    if (mdl_clr) begin
      pend <= 2'd0;
      rd_q <= 32'h0;
    end else if (m_bus.valid && m_bus.ready) begin
      if (m_bus.wen) begin
        for (int b = 0; b < 4; b++)
          if (m_bus.wmask[b]) mem[m_bus.addr[9:2]][8*b +: 8] <= m_bus.wdata[8*b +: 8];
        pend <= 2'd2;
        rd_q <= 32'h0;
      end else begin
        rd_q <= mem[m_bus.addr[9:2]];
        pend <= 2'd1;
      end
    end else if (pend != 2'd0) begin
      pend <= pend - 2'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor(input logic [7:0] idx, input logic [31:0] dat);
    bd_idx = idx;
    bd_dat = dat;
    bd_en  = 1'b1;
    tick();
    bd_en  = 1'b0;
  endtask

  task automatic drive_i(input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] m);
    i_bus.valid = v; i_bus.addr = a; i_bus.wen = w; i_bus.wdata = wd; i_bus.wmask = m;
  endtask

  task automatic drive_d(input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] m);
    d_bus.valid = v; d_bus.addr = a; d_bus.wen = w; d_bus.wdata = wd; d_bus.wmask = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_i_rvalid got %b exp 0", i_bus.rvalid); end
    checks++; if (d_bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid got %b exp 0", d_bus.rvalid); end
    checks++; if (m_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_bus.valid); end
    checks++; if ({i_bus.ready, d_bus.ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {i_bus.ready, d_bus.ready}); end
  endtask

  task automatic test_single_read();
    tick();
    drive_i(1'b1, 32'h10, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (m_bus.valid !== 1'b1 || m_bus.addr !== 32'h10) begin errors++; $display("FAIL single_issue got v=%b a=%h exp v=1 a=10", m_bus.valid, m_bus.addr); end
    checks++; if ({i_bus.ready, d_bus.ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {i_bus.ready, d_bus.ready}); end
    tick();
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b1 || i_bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_resp got rv=%b d=%h exp rv=1 d=deadbeef", i_bus.rvalid, i_bus.rdata); end
    checks++; if (d_bus.rvalid !== 1'b0) begin errors++; $display("FAIL single_d_rvalid got %b exp 0", d_bus.rvalid); end
    tick();
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b0) begin errors++; $display("FAIL single_one_resp got %b exp 0", i_bus.rvalid); end
  endtask

  task automatic test_dual_read();
    tick();
    drive_i(1'b1, 32'h4, 1'b0, 32'h0, 4'h0);
    drive_d(1'b1, 32'h8, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if ({i_bus.ready, d_bus.ready} !== 2'b01 || m_bus.addr !== 32'h8) begin errors++; $display("FAIL dual_first got rdy=%b a=%h exp rdy=01 a=8", {i_bus.ready, d_bus.ready}, m_bus.addr); end
    tick();
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (d_bus.rvalid !== 1'b1 || d_bus.rdata !== 32'h08080808 || i_bus.rvalid !== 1'b0) begin errors++; $display("FAIL dual_d_resp got drv=%b d=%h irv=%b exp 1 08080808 0", d_bus.rvalid, d_bus.rdata, i_bus.rvalid); end
    checks++; if (i_bus.ready !== 1'b1 || m_bus.addr !== 32'h4) begin errors++; $display("FAIL dual_second got rdy=%b a=%h exp rdy=1 a=4", i_bus.ready, m_bus.addr); end
    tick();
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b1 || i_bus.rdata !== 32'h04040404 || d_bus.rvalid !== 1'b0) begin errors++; $display("FAIL dual_i_resp got irv=%b d=%h drv=%b exp 1 04040404 0", i_bus.rvalid, i_bus.rdata, d_bus.rvalid); end
  endtask

  task automatic test_write_read();
    tick();
    drive_d(1'b1, 32'h20, 1'b1, 32'h11223344, 4'b0011);
    @(negedge clk);
    checks++; if (d_bus.ready !== 1'b1 || m_bus.wen !== 1'b1 || m_bus.wmask !== 4'b0011) begin errors++; $display("FAIL wr_issue got rdy=%b wen=%b m=%b exp 1 1 0011", d_bus.ready, m_bus.wen, m_bus.wmask); end
    tick();
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_i(1'b1, 32'h20, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (i_bus.ready !== 1'b0 || d_bus.rvalid !== 1'b0) begin errors++; $display("FAIL wr_busy got irdy=%b drv=%b exp 0 0", i_bus.ready, d_bus.rvalid); end
    tick();
    @(negedge clk);
    checks++; if (d_bus.rvalid !== 1'b1 || i_bus.ready !== 1'b1) begin errors++; $display("FAIL wr_ack got drv=%b irdy=%b exp 1 1", d_bus.rvalid, i_bus.ready); end
    tick();
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b1 || i_bus.rdata !== 32'hAABB3344) begin errors++; $display("FAIL wr_readback got rv=%b d=%h exp 1 aabb3344", i_bus.rvalid, i_bus.rdata); end
  endtask

  task automatic test_stall();
    tick();
    mem_rdy = 1'b0;
    drive_d(1'b1, 32'h8, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (m_bus.valid !== 1'b1 || d_bus.ready !== 1'b0) begin errors++; $display("FAIL stall_c0 got v=%b drdy=%b exp 1 0", m_bus.valid, d_bus.ready); end
    tick();
    tick();
    drive_i(1'b1, 32'h4, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h8 || {i_bus.ready, d_bus.ready} !== 2'b00) begin errors++; $display("FAIL stall_hold_d got a=%h rdy=%b exp 8 00", m_bus.addr, {i_bus.ready, d_bus.ready}); end
    tick();
    mem_rdy = 1'b1;
    @(negedge clk);
    checks++; if ({i_bus.ready, d_bus.ready} !== 2'b01) begin errors++; $display("FAIL stall_release_d got %b exp 01", {i_bus.ready, d_bus.ready}); end
    tick();
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (d_bus.rvalid !== 1'b1 || i_bus.ready !== 1'b1) begin errors++; $display("FAIL stall_d_resp got drv=%b irdy=%b exp 1 1", d_bus.rvalid, i_bus.ready); end
    tick();
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    // Same again with I stalled first: the late D request must not steal the grant.
    tick();
    mem_rdy = 1'b0;
    drive_i(1'b1, 32'h10, 1'b0, 32'h0, 4'h0);
    tick();
    drive_d(1'b1, 32'h8, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h10 || d_bus.ready !== 1'b0) begin errors++; $display("FAIL stall_hold_i got a=%h drdy=%b exp 10 0", m_bus.addr, d_bus.ready); end
    tick();
    mem_rdy = 1'b1;
    @(negedge clk);
    checks++; if ({i_bus.ready, d_bus.ready} !== 2'b10) begin errors++; $display("FAIL stall_release_i got %b exp 10", {i_bus.ready, d_bus.ready}); end
    tick();
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b1 || i_bus.rdata !== 32'hDEADBEEF || d_bus.ready !== 1'b1) begin errors++; $display("FAIL stall_i_resp got irv=%b d=%h drdy=%b exp 1 deadbeef 1", i_bus.rvalid, i_bus.rdata, d_bus.ready); end
    tick();
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (d_bus.rvalid !== 1'b1) begin errors++; $display("FAIL stall_d_final got %b exp 1", d_bus.rvalid); end
  endtask

  task automatic test_reset_busy();
    tick();
    drive_d(1'b1, 32'h24, 1'b1, 32'h55667788, 4'hF);
    @(negedge clk);
    checks++; if (d_bus.ready !== 1'b1) begin errors++; $display("FAIL rstb_accept got %b exp 1", d_bus.ready); end
    tick();
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_i(1'b1, 32'h10, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if ({i_bus.rvalid, d_bus.rvalid} !== 2'b00) begin errors++; $display("FAIL rstb_stale_drop got %b exp 00", {i_bus.rvalid, d_bus.rvalid}); end
    checks++; if (i_bus.ready !== 1'b1) begin errors++; $display("FAIL rstb_idle_issue got %b exp 1", i_bus.ready); end
    tick();
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (i_bus.rvalid !== 1'b1 || i_bus.rdata !== 32'hDEADBEEF || d_bus.rvalid !== 1'b0) begin errors++; $display("FAIL rstb_after got irv=%b d=%h drv=%b exp 1 deadbeef 0", i_bus.rvalid, i_bus.rdata, d_bus.rvalid); end
  endtask

  task automatic test_back_to_back();
    int   n_acc = 0;
    int   n_ri = 0;
    int   n_rd = 0;
    int   c_first = -1;
    int   c_last = -1;
    logic exp_d = 1'b1;
    tick();
    drive_i(1'b1, 32'h10, 1'b0, 32'h0, 4'h0);
    drive_d(1'b1, 32'h8, 1'b0, 32'h0, 4'h0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i_bus.rvalid) begin
        n_ri++;
        checks++; if (i_bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_i_data got %h exp deadbeef", i_bus.rdata); end
      end
      if (d_bus.rvalid) begin
        n_rd++;
        checks++; if (d_bus.rdata !== 32'h08080808) begin errors++; $display("FAIL b2b_d_data got %h exp 08080808", d_bus.rdata); end
      end
      if (i_bus.ready || d_bus.ready) begin
        checks++; if ({i_bus.ready, d_bus.ready} !== {~exp_d, exp_d}) begin errors++; $display("FAIL b2b_grant n=%0d got %b exp %b", n_acc, {i_bus.ready, d_bus.ready}, {~exp_d, exp_d}); end
        if (c_first < 0) c_first = c;
        c_last = c;
        n_acc++;
        exp_d = RR ? ~exp_d : D_PRIO;
      end
      if (n_acc >= 8 && n_ri + n_rd >= 8) break;
      tick();
      if (n_acc >= 8) begin
        drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      end
    end
    checks++; if (n_acc != 8) begin errors++; $display("FAIL b2b_accepts got %0d exp 8", n_acc); end
    checks++; if (n_ri != (RR ? 4 : 0) || n_rd != (RR ? 4 : 8)) begin errors++; $display("FAIL b2b_resp_count got i=%0d d=%0d exp i=%0d d=%0d", n_ri, n_rd, RR ? 4 : 0, RR ? 4 : 8); end
    checks++; if (c_last - c_first != 7) begin errors++; $display("FAIL b2b_throughput got span %0d exp 7", c_last - c_first); end
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:15];
    bit          pv [2];
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pwd [2];
    logic [3:0]  pm [2];
    int          q_own [$];
    bit          q_wr [$];
    logic [31:0] q_dat [$];
    int          lock = -1;
    int          last = 1;
    int          win;
    int          k;
    bit          issue;
    bit          rdy;
    logic        exp_ri;
    logic        exp_rd;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      ref_mem[j] = $urandom;
      backdoor(8'(32 + j), ref_mem[j]);
    end
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int c = 0; c < 360; c++) begin
      tick();
      rdy = (c >= 300) || ($urandom_range(3) != 0);
      mem_rdy = rdy;
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && c < 300 && $urandom_range(2) == 0) begin
          pv[p]  = 1'b1;
          pw[p]  = 1'($urandom_range(1));
          pa[p]  = 32'h80 + (32'($urandom_range(15)) << 2);
          pwd[p] = $urandom;
          pm[p]  = 4'($urandom_range(15));
        end
      end
      drive_i(pv[0], pa[0], pw[0], pwd[0], pm[0]);
      drive_d(pv[1], pa[1], pw[1], pwd[1], pm[1]);
      @(negedge clk);
      issue = (q_own.size() == 0) || m_bus.rvalid;
      win = -1;
      if (issue) begin
        if (lock >= 0) win = lock;
        else if (pv[0] && pv[1]) win = RR ? 1 - last : int'(D_PRIO);
        else if (pv[0]) win = 0;
        else if (pv[1]) win = 1;
      end
      checks++; if (m_bus.valid !== (win >= 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, m_bus.valid, win >= 0); end
      checks++; if ({i_bus.ready, d_bus.ready} !== {win == 0 && rdy, win == 1 && rdy}) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, {i_bus.ready, d_bus.ready}, {win == 0 && rdy, win == 1 && rdy}); end
      if (win >= 0) begin
        checks++;
        if ({m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask} !== {pa[win], pw[win], pwd[win], pm[win]}) begin
          errors++; $display("FAIL rnd_fwd c=%0d got %h/%b/%h/%b exp %h/%b/%h/%b", c, m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask, pa[win], pw[win], pwd[win], pm[win]);
        end
      end
      exp_ri = m_bus.rvalid && q_own.size() > 0 && q_own[0] == 0;
      exp_rd = m_bus.rvalid && q_own.size() > 0 && q_own[0] == 1;
      checks++; if ({i_bus.rvalid, d_bus.rvalid} !== {exp_ri, exp_rd}) begin errors++; $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, {i_bus.rvalid, d_bus.rvalid}, {exp_ri, exp_rd}); end
      if ((exp_ri || exp_rd) && !q_wr[0]) begin
        checks++; if ((exp_ri ? i_bus.rdata : d_bus.rdata) !== q_dat[0]) begin errors++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, exp_ri ? i_bus.rdata : d_bus.rdata, q_dat[0]); end
      end
      if (m_bus.rvalid && q_own.size() > 0) begin
        void'(q_own.pop_front());
        void'(q_wr.pop_front());
        void'(q_dat.pop_front());
      end
      if (win >= 0) begin
        if (rdy) begin
          k = int'((pa[win] - 32'h80) >> 2);
          q_own.push_back(win);
          q_wr.push_back(pw[win]);
          q_dat.push_back(pw[win] ? 32'h0 : ref_mem[k]);
          if (pw[win])
            for (int b = 0; b < 4; b++)
              if (pm[win][b]) ref_mem[k][8*b +: 8] = pwd[win][8*b +: 8];
          pv[win] = 1'b0;
          lock = -1;
          last = win;
        end else begin
          lock = win;
        end
      end
    end
    checks++; if (q_own.size() != 0 || pv[0] || pv[1]) begin errors++; $display("FAIL rnd_drain got outstanding=%0d pending=%b%b exp 0 00", q_own.size(), pv[0], pv[1]); end
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    mdl_clr = 1'b1;
    mem_rdy = 1'b1;
    bd_en = 1'b0;
    bd_idx = 8'h0;
    bd_dat = 32'h0;
    drive_i(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_d(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    mdl_clr = 1'b0;
    backdoor(8'd4, 32'hDEADBEEF);
    backdoor(8'd1, 32'h04040404);
    backdoor(8'd2, 32'h08080808);
    backdoor(8'd8, 32'hAABBCCDD);
    test_reset();
    test_single_read();
    test_dual_read();
    test_write_read();
    test_stall();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
